data_mem_responder: RTL and testbench



---
 rtl/bus_pkg.sv | 15 +
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/bus_lane_align.sv | 80 ++++++++
 rtl/data_mem_responder.sv | 129 ++++++++++++
 tb/tb_data_mem_responder.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared encodings for the data-memory bus responder: FSM states,
// funct3 access-size codes and the internal access-width classification.
package bus_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} bus_state_e;

   localparam logic [2:0] SIZE_B  = 3'b000;
   localparam logic [2:0] SIZE_H  = 3'b001;
   localparam logic [2:0] SIZE_W  = 3'b010;
   localparam logic [2:0] SIZE_BU = 3'b100;
   localparam logic [2:0] SIZE_HU = 3'b101;

   typedef enum logic [1:0] {ACC_BYTE, ACC_HALF, ACC_WORD} acc_width_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store bus between the CPU datapath (master) and the data RAM (slave).
interface data_mem_responder_if;

   logic        busReq;
   logic        busWe;
   logic [2:0]  busSize;
   logic [31:0] busAddr;
   logic [31:0] busWData;
   logic [31:0] busRData;
   logic        busReady;
   logic        busErr;

   modport master (
      output busReq, busWe, busSize, busAddr, busWData,
      input  busRData, busReady, busErr
   );

   modport slave (
      input  busReq, busWe, busSize, busAddr, busWData,
      output busRData, busReady, busErr
   );

endinterface

// File: rtl/bus_lane_align.sv
// Byte-lane steering for the data RAM: store byte enables / replicated write word,
// and load lane select with zero/sign extension. DATA_MEM_ERR_EN turns misaligned or
// undefined accesses into errors; otherwise they are aligned down / treated as words.
module bus_lane_align
   import bus_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  byte_en,
   output logic [31:0] wword,
   output logic [31:0] rdata,
   output logic        err
);

   acc_width_e  width;
   logic        sext;
   logic [1:0]  off;
   logic [31:0] shifted;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path infers a latch.
      width = ACC_WORD;
      sext  = 1'b0;
      err   = 1'b0;
      off   = addr_lo;
      case (size)
         SIZE_B:  begin width = ACC_BYTE; sext = 1'b1; end
         SIZE_BU: width = ACC_BYTE;
         SIZE_H:  begin width = ACC_HALF; sext = 1'b1; end
         SIZE_HU: width = ACC_HALF;
         SIZE_W:  width = ACC_WORD;
         default: begin
`ifdef DATA_MEM_ERR_EN
            err = 1'b1;
`endif
         end
      endcase
`ifdef DATA_MEM_ERR_EN
      if ((width == ACC_HALF && off[0]) || (width == ACC_WORD && off != 2'b00))
         err = 1'b1;
`else
      if (width == ACC_HALF)
         off[0] = 1'b0;
      else if (width == ACC_WORD)
         off = 2'b00;
`endif
   end

   // Store data is replicated across lanes so the byte enables alone pick the target bytes.
   always_comb begin
      shifted = rword >> {off, 3'b000};
      byte_en = 4'b1111;
      wword   = wdata;
      rdata   = shifted;
      case (width)
         ACC_BYTE: begin
            byte_en = 4'b0001 << off;
            wword   = {4{wdata[7:0]}};
            rdata   = {{24{sext & shifted[7]}}, shifted[7:0]};
         end
         ACC_HALF: begin
            byte_en = 4'b0011 << off;
            wword   = {2{wdata[15:0]}};
            rdata   = {{16{sext & shifted[15]}}, shifted[15:0]};
         end
         default: begin
            byte_en = 4'b1111;
            wword   = wdata;
            rdata   = shifted;
         end
      endcase
      if (err) begin
         byte_en = 4'b0000;
         rdata   = 32'h0;
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data RAM bus responder: one access at a time, WAIT_STATES wait cycles, one-cycle busReady.
// Build option DATA_MEM_ERR_EN reports misaligned/undefined accesses on busErr.
module data_mem_responder
   import bus_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1
) (
   input logic                 clk,
   input logic                 reset,
   data_mem_responder_if.slave bus
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   bus_state_e    state;
   logic [3:0]    cnt;
   logic [AW+1:0] addr_q;
   logic [31:0]   wdata_q;
   logic          we_q;
   logic [2:0]    size_q;
   logic          ready_q;
   logic          err_q;
   logic [31:0]   rdata_q;

   logic [31:0]   mem [DEPTH];

   logic [AW+1:0] acc_addr;
   logic [31:0]   acc_wdata;
   logic          acc_we;
   logic [2:0]    acc_size;
   logic [AW-1:0] acc_idx;
   logic          take_req;
   logic          enter_resp;
   logic [3:0]    byte_en;
   logic [31:0]   wword;
   logic [31:0]   ld_data;
   logic          acc_err;
   logic          unused_addr_hi;

   // In IDLE the access comes straight off the bus so a zero-wait load reads on its capture edge.
   always_comb begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_we    = we_q;
      acc_size  = size_q;
      if (state == IDLE) begin
         acc_addr  = bus.busAddr[AW+1:0];
         acc_wdata = bus.busWData;
         acc_we    = bus.busWe;
         acc_size  = bus.busSize;
      end
   end

   assign acc_idx        = acc_addr[AW+1:2];
   assign take_req       = (state == IDLE) && bus.busReq;
   assign enter_resp     = (take_req && (WAIT_STATES == 0)) || (state == WAIT && cnt == 4'd0);
   assign unused_addr_hi = ^bus.busAddr[31:AW+2];

   bus_lane_align u_align (
      .size    (acc_size),
      .addr_lo (acc_addr[1:0]),
      .wdata   (acc_wdata),
      .rword   (mem[acc_idx]),
      .byte_en (byte_en),
      .wword   (wword),
      .rdata   (ld_data),
      .err     (acc_err)
   );

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         we_q    <= 1'b0;
         size_q  <= 3'b000;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         ready_q <= enter_resp;
         err_q   <= enter_resp & acc_err;
         rdata_q <= (enter_resp && !acc_we) ? ld_data : 32'h0;
         case (state)
            IDLE: begin
               if (bus.busReq) begin
                  addr_q  <= bus.busAddr[AW+1:0];
                  wdata_q <= bus.busWData;
                  we_q    <= bus.busWe;
                  size_q  <= bus.busSize;
                  if (WAIT_STATES > 0) begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end else begin
                     state <= RESP;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0)
                  state <= RESP;
               else
                  cnt <= cnt - 4'd1;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: the array has no reset; a reset during an access aborts it because state leaves RESP.
   always_ff @(posedge clk) begin
      if (state == RESP && we_q) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i])
               mem[acc_idx][8*i +: 8] <= wword[8*i +: 8];
         end
      end
   end

   assign bus.busReady = ready_q;
   assign bus.busErr   = err_q;
   assign bus.busRData = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: three instances (WAIT_STATES 1, 0, 3)
// compared against a byte-level memory model with randomized and directed accesses.
module tb_data_mem_responder;
   import bus_pkg::*;

   localparam int DEPTH = 256;
   localparam int NDUT  = 3;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_pass  = 0;
   int   n_total = 0;

   logic [31:0] model_mem [NDUT][DEPTH];

   data_mem_responder_if b0 ();
   data_mem_responder_if b1 ();
   data_mem_responder_if b2 ();

   data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(1)) u_dut     (.clk(clk), .reset(reset), .bus(b0));
   data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut_ws0 (.clk(clk), .reset(reset), .bus(b1));
   data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_dut_ws3 (.clk(clk), .reset(reset), .bus(b2));

   always #5 clk = ~clk;

   function automatic int ws_of(input int d);
      case (d)
         0:       return 1;
         1:       return 0;
         default: return 3;
      endcase
   endfunction

   task automatic drive(input int d, input logic req, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
      case (d)
         0: begin b0.busReq = req; b0.busWe = we; b0.busSize = size; b0.busAddr = addr; b0.busWData = wdata; end
         1: begin b1.busReq = req; b1.busWe = we; b1.busSize = size; b1.busAddr = addr; b1.busWData = wdata; end
         default: begin b2.busReq = req; b2.busWe = we; b2.busSize = size; b2.busAddr = addr; b2.busWData = wdata; end
      endcase
   endtask

   task automatic sample(input int d, output logic rdy, output logic err, output logic [31:0] rd);
      case (d)
         0: begin rdy = b0.busReady; err = b0.busErr; rd = b0.busRData; end
         1: begin rdy = b1.busReady; err = b1.busErr; rd = b1.busRData; end
         default: begin rdy = b2.busReady; err = b2.busErr; rd = b2.busRData; end
      endcase
   endtask

   // Reference: byte-addressed view of each word; updates the model on successful stores.
   function automatic void model(input int d, input logic we, input logic [2:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] exp_rd, output logic exp_err);
      int nbytes, off, idx;
      bit sgn, bad;
      longint unsigned v, mask;
      idx = int'(addr[9:2]);
      off = int'(addr[1:0]);
      sgn = 1'b0;
      bad = 1'b0;
      nbytes = 4;
      case (size)
         3'b000: begin nbytes = 1; sgn = 1'b1; end
         3'b100: nbytes = 1;
         3'b001: begin nbytes = 2; sgn = 1'b1; end
         3'b101: nbytes = 2;
         3'b010: nbytes = 4;
         default: bad = 1'b1;
      endcase
`ifdef DATA_MEM_ERR_EN
      if (off % nbytes != 0) bad = 1'b1;
`else
      bad = 1'b0;
      off = off - (off % nbytes);
`endif
      exp_rd  = 32'h0;
      exp_err = bad;
      if (bad) return;
      if (we) begin
         for (int b = 0; b < nbytes; b++)
            model_mem[d][idx][8*(off+b) +: 8] = wdata[8*b +: 8];
      end else begin
         mask = (64'd1 << (8*nbytes)) - 64'd1;
         v = ({32'd0, model_mem[d][idx]} >> (8*off)) & mask;
         if (sgn && v[8*nbytes-1]) v = v | ~mask;
         exp_rd = v[31:0];
      end
   endfunction

   // One access with busReq dropped for one cycle afterwards; called and returns at posedge+1.
   task automatic access(input int d, input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd, output logic err,
                         output int lat, output logic tail_ok);
      logic rdy, e2;
      logic [31:0] r2;
      int n;
      n = 0;
      rdy = 1'b0;
      err = 1'b0;
      rd = 32'h0;
      drive(d, 1'b1, we, size, addr, wdata);
      while (!rdy && n < 40) begin
         @(posedge clk); #1;
         n++;
         sample(d, rdy, err, rd);
      end
      lat = rdy ? n : -1;
      drive(d, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(posedge clk); #1;
      sample(d, rdy, e2, r2);
      tail_ok = !rdy && !e2 && (r2 == 32'h0);
   endtask

   task automatic test_reset();
      logic rdy, err;
      logic [31:0] rd;
      reset = 1'b0;
      for (int d = 0; d < NDUT; d++) drive(d, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      drive(0, 1'b1, 1'b0, SIZE_W, 32'h10, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
         sample(d, rdy, err, rd);
         n_total++;
         if ({rdy, err, rd} !== 34'h0) $display("FAIL reset_held[%0d]: ready=%b err=%b rdata=%h, want 0/0/0", d, rdy, err, rd);
         else n_pass++;
      end
      drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
         sample(d, rdy, err, rd);
         n_total++;
         if ({rdy, err, rd} !== 34'h0) $display("FAIL reset_release[%0d]: ready=%b err=%b rdata=%h, want 0/0/0", d, rdy, err, rd);
         else n_pass++;
      end
   endtask

   task automatic test_fill();
      logic [31:0] rd, exp_rd, wd;
      logic err, exp_err, tail;
      int lat, bad;
      for (int d = 0; d < NDUT; d++) begin
         bad = 0;
         for (int i = 0; i < DEPTH; i++) begin
            wd = $urandom;
            model(d, 1'b1, SIZE_W, 32'(i*4), wd, exp_rd, exp_err);
            access(d, 1'b1, SIZE_W, 32'(i*4), wd, rd, err, lat, tail);
            if (lat != ws_of(d) + 1 || err !== 1'b0 || rd !== 32'h0 || !tail) bad++;
         end
         n_total++;
         if (bad != 0) $display("FAIL fill[%0d]: %0d bad store responses, want 0", d, bad);
         else n_pass++;
      end
   endtask

   task automatic test_word();
      logic [31:0] rd, exp_rd;
      logic err, exp_err, tail;
      int lat;
      model(0, 1'b1, SIZE_W, 32'h10, 32'hDEAD_BEEF, exp_rd, exp_err);
      access(0, 1'b1, SIZE_W, 32'h10, 32'hDEAD_BEEF, rd, err, lat, tail);
      n_total++;
      if (lat != 2 || err !== 1'b0) $display("FAIL sw_0x10: latency=%0d err=%b, want 2/0", lat, err);
      else n_pass++;
      model(0, 1'b0, SIZE_W, 32'h10, 32'h0, exp_rd, exp_err);
      access(0, 1'b0, SIZE_W, 32'h10, 32'h0, rd, err, lat, tail);
      n_total++;
      if (rd !== 32'hDEAD_BEEF) $display("FAIL lw_0x10: rdata=%h, want deadbeef", rd);
      else n_pass++;
      n_total++;
      if (lat != 2 || !tail) $display("FAIL lw_0x10_timing: latency=%0d single_pulse=%b, want 2/1", lat, tail);
      else n_pass++;
   endtask

   task automatic test_byte();
      logic [31:0] rd, exp_rd;
      logic err, exp_err, tail;
      int lat;
      model(0, 1'b1, SIZE_B, 32'h11, 32'h80, exp_rd, exp_err);
      access(0, 1'b1, SIZE_B, 32'h11, 32'h80, rd, err, lat, tail);
      access(0, 1'b0, SIZE_B, 32'h11, 32'h0, rd, err, lat, tail);
      n_total++;
      if (rd !== 32'hFFFF_FF80) $display("FAIL lb_0x11: rdata=%h, want ffffff80", rd);
      else n_pass++;
      access(0, 1'b0, SIZE_BU, 32'h11, 32'h0, rd, err, lat, tail);
      n_total++;
      if (rd !== 32'h0000_0080) $display("FAIL lbu_0x11: rdata=%h, want 00000080", rd);
      else n_pass++;
      access(0, 1'b0, SIZE_W, 32'h10, 32'h0, rd, err, lat, tail);
      n_total++;
      if (rd !== 32'hDEAD_80EF) $display("FAIL lw_0x10_after_sb: rdata=%h, want dead80ef", rd);
      else n_pass++;
   endtask

   task automatic test_half();
      logic [31:0] rd, exp_rd, prior;
      logic err, exp_err, tail;
      int lat;
      prior = model_mem[0][8];
      model(0, 1'b1, SIZE_H, 32'h22, 32'h9ABC, exp_rd, exp_err);
      access(0, 1'b1, SIZE_H, 32'h22, 32'h9ABC, rd, err, lat, tail);
      access(0, 1'b0, SIZE_H, 32'h22, 32'h0, rd, err, lat, tail);
      n_total++;
      if (rd !== 32'hFFFF_9ABC) $display("FAIL lh_0x22: rdata=%h, want ffff9abc", rd);
      else n_pass++;
      access(0, 1'b0, SIZE_HU, 32'h22, 32'h0, rd, err, lat, tail);
      n_total++;
      if (rd !== 32'h0000_9ABC) $display("FAIL lhu_0x22: rdata=%h, want 00009abc", rd);
      else n_pass++;
      access(0, 1'b0, SIZE_W, 32'h20, 32'h0, rd, err, lat, tail);
      n_total++;
      if (rd !== {16'h9ABC, prior[15:0]}) $display("FAIL lw_0x20_after_sh: rdata=%h, want %h", rd, {16'h9ABC, prior[15:0]});
      else n_pass++;
   endtask

   task automatic test_misaligned();
      logic [31:0] rd, exp_rd;
      logic err, exp_err, tail;
      int lat;
      access(0, 1'b0, SIZE_W, 32'h13, 32'h0, rd, err, lat, tail);
`ifdef DATA_MEM_ERR_EN
      n_total++;
      if (err !== 1'b1 || rd !== 32'h0 || lat != 2) $display("FAIL lw_0x13_err: err=%b rdata=%h latency=%0d, want 1/0/2", err, rd, lat);
      else n_pass++;
      model(0, 1'b1, SIZE_W, 32'h13, 32'hFFFF_FFFF, exp_rd, exp_err);
      access(0, 1'b1, SIZE_W, 32'h13, 32'hFFFF_FFFF, rd, err, lat, tail);
      n_total++;
      if (err !== 1'b1) $display("FAIL sw_0x13_err: err=%b, want 1", err);
      else n_pass++;
      access(0, 1'b0, SIZE_W, 32'h10, 32'h0, rd, err, lat, tail);
      n_total++;
      if (rd !== 32'hDEAD_80EF) $display("FAIL lw_0x10_after_bad_sw: rdata=%h, want dead80ef", rd);
      else n_pass++;
      access(0, 1'b0, SIZE_H, 32'h23, 32'h0, rd, err, lat, tail);
      n_total++;
      if (err !== 1'b1 || rd !== 32'h0) $display("FAIL lh_0x23_err: err=%b rdata=%h, want 1/0", err, rd);
      else n_pass++;
      access(0, 1'b0, 3'b011, 32'h10, 32'h0, rd, err, lat, tail);
      n_total++;
      if (err !== 1'b1 || rd !== 32'h0) $display("FAIL undef_size_err: err=%b rdata=%h, want 1/0", err, rd);
      else n_pass++;
`else
      n_total++;
      if (err !== 1'b0 || rd !== 32'hDEAD_80EF || lat != 2) $display("FAIL lw_0x13_align: err=%b rdata=%h latency=%0d, want 0/dead80ef/2", err, rd, lat);
      else n_pass++;
      access(0, 1'b0, SIZE_H, 32'h23, 32'h0, rd, err, lat, tail);
      n_total++;
      if (err !== 1'b0 || rd !== 32'hFFFF_9ABC) $display("FAIL lh_0x23_align: err=%b rdata=%h, want 0/ffff9abc", err, rd);
      else n_pass++;
      access(0, 1'b0, 3'b011, 32'h10, 32'h0, rd, err, lat, tail);
      n_total++;
      if (err !== 1'b0 || rd !== 32'hDEAD_80EF) $display("FAIL undef_size_as_w: err=%b rdata=%h, want 0/dead80ef", err, rd);
      else n_pass++;
`endif
   endtask

   task automatic test_reset_abort();
      logic [31:0] rd, old;
      logic err, tail, seen;
      int lat;
      old = model_mem[0][12];
      drive(0, 1'b1, 1'b1, SIZE_W, 32'h30, 32'h1234_5678);
      @(posedge clk); #1;
      reset = 1'b0;
      drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (b0.busReady !== 1'b0) seen = 1'b1;
      end
      reset = 1'b1;
      n_total++;
      if (seen !== 1'b0) $display("FAIL abort_no_ready: ready seen=%b, want 0", seen);
      else n_pass++;
      @(posedge clk); #1;
      access(0, 1'b0, SIZE_W, 32'h30, 32'h0, rd, err, lat, tail);
      n_total++;
      if (rd !== old) $display("FAIL abort_no_write: rdata=%h, want %h", rd, old);
      else n_pass++;
      n_total++;
      if (lat != 2 || !tail) $display("FAIL abort_idle: latency=%0d single_pulse=%b, want 2/1", lat, tail);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd, exp_rd, exp_a, exp_b, a, b;
      logic err, exp_err, tail, rdy;
      int lat, n;
      for (int d = 1; d < NDUT; d++) begin
         for (int k = 0; k < 4; k++) begin
            a = $urandom & 32'hFFFF_FFFC;
            model(d, 1'b0, SIZE_W, a, 32'h0, exp_rd, exp_err);
            access(d, 1'b0, SIZE_W, a, 32'h0, rd, err, lat, tail);
            n_total++;
            if (rd !== exp_rd || lat != ws_of(d) + 1 || !tail)
               $display("FAIL b2b[%0d.%0d]: rdata=%h latency=%0d single_pulse=%b, want %h/%0d/1", d, k, rd, lat, tail, exp_rd, ws_of(d) + 1);
            else n_pass++;
         end
         a = $urandom & 32'hFFFF_FFFC;
         b = $urandom & 32'hFFFF_FFFC;
         model(d, 1'b0, SIZE_W, a, 32'h0, exp_a, exp_err);
         model(d, 1'b0, SIZE_W, b, 32'h0, exp_b, exp_err);
         drive(d, 1'b1, 1'b0, SIZE_W, a, 32'h0);
         n = 0; rdy = 1'b0; rd = 32'h0;
         while (!rdy && n < 40) begin @(posedge clk); #1; n++; sample(d, rdy, err, rd); end
         n_total++;
         if (!rdy || n != ws_of(d) + 1 || rd !== exp_a)
            $display("FAIL held_first[%0d]: cycles=%0d rdata=%h, want %0d/%h", d, n, rd, ws_of(d) + 1, exp_a);
         else n_pass++;
         drive(d, 1'b1, 1'b0, SIZE_W, b, 32'h0);
         n = 0; rdy = 1'b0; rd = 32'h0;
         while (!rdy && n < 40) begin @(posedge clk); #1; n++; sample(d, rdy, err, rd); end
         n_total++;
         if (!rdy || n != ws_of(d) + 2 || rd !== exp_b)
            $display("FAIL held_second[%0d]: cycles=%0d rdata=%h, want %0d/%h", d, n, rd, ws_of(d) + 2, exp_b);
         else n_pass++;
         drive(d, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
         @(posedge clk); #1;
         sample(d, rdy, err, rd);
         n_total++;
         if (rdy !== 1'b0) $display("FAIL held_release[%0d]: ready=%b, want 0", d, rdy);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [2:0]  sz_tab [8];
      logic [31:0] addr, wd, rd, exp_rd;
      logic we, err, exp_err, tail;
      int lat, pick;
      sz_tab = '{SIZE_B, SIZE_H, SIZE_W, SIZE_BU, SIZE_HU, 3'b011, 3'b110, 3'b111};
      for (int d = 0; d < NDUT; d++) begin
         for (int k = 0; k < 80; k++) begin
            pick = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
            we   = 1'($urandom_range(0, 1));
            addr = $urandom;
            wd   = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            model(d, we, sz_tab[pick], addr, wd, exp_rd, exp_err);
            access(d, we, sz_tab[pick], addr, wd, rd, err, lat, tail);
            n_total++;
            if (rd !== exp_rd) $display("FAIL rand_rdata[%0d.%0d]: we=%b size=%b addr=%h rdata=%h, want %h", d, k, we, sz_tab[pick], addr, rd, exp_rd);
            else n_pass++;
            n_total++;
            if (err !== exp_err) $display("FAIL rand_err[%0d.%0d]: size=%b addr=%h err=%b, want %b", d, k, sz_tab[pick], addr, err, exp_err);
            else n_pass++;
            n_total++;
            if (lat != ws_of(d) + 1 || !tail) $display("FAIL rand_timing[%0d.%0d]: latency=%0d single_pulse=%b, want %0d/1", d, k, lat, tail, ws_of(d) + 1);
            else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_word();
      test_byte();
      test_half();
      test_misaligned();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached after %0d checks", n_total);
      $fatal(1);
   end

endmodule
